// File: rtl/npc_pkg.sv
// Shared integer-core definitions: data width, register-file geometry and index type.
package npc_pkg;
  localparam int XLEN    = 32;
  localparam int REG_NUM = 32;
  localparam int REG_AW  = 5;

  typedef logic [REG_AW-1:0] reg_idx_t;
endpackage

// File: rtl/gpr_wb_scoreboard_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i, modulo N.
// Zero latency; the pointer register is owned by the instantiating block.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o
);

  int   idx;
  logic found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = PW'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpr_wb_scoreboard.sv
// GPR write-back arbiter plus busy scoreboard: one registered write per cycle (1-cycle latency).
// Requesters are held off via one-hot wb_ready; issue is held off via iss_ready on RAW/WAW hazards.
module gpr_wb_scoreboard
  import npc_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = npc_pkg::XLEN,
  parameter int CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    iss_valid,
  input  logic [4:0]              iss_rs1,
  input  logic [4:0]              iss_rs2,
  input  logic [4:0]              iss_rd,
  input  logic                    iss_use_rs1,
  input  logic                    iss_use_rs2,
  input  logic                    iss_rd_wen,
  output logic                    iss_ready,
  input  logic [NUM_REQ-1:0]      wb_valid,
  input  logic [NUM_REQ*5-1:0]    wb_rd,
  input  logic [NUM_REQ*XLEN-1:0] wb_data,
  output logic [NUM_REQ-1:0]      wb_ready,
  output logic                    gpr_wen,
  output logic [4:0]              gpr_waddr,
  output logic [XLEN-1:0]         gpr_wdata,
  output logic [31:0]             busy_vec,
  output logic                    err_unexp_wb,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_vld;
  reg_idx_t           sel_rd;
  logic [XLEN-1:0]    sel_data;
  logic               wr_vld;
  logic               iss_fire;

  logic [REG_NUM-1:0] busy_q, busy_d;
  logic               wen_q, wen_d;
  reg_idx_t           waddr_q, waddr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  rr_arbiter #(.N(NUM_REQ), .PW(PTR_W)) u_arb (
    .req_i     (wb_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign gnt_vld  = |gnt;
  assign wb_ready = gnt;
  assign sel_rd   = wb_rd[REG_AW*gnt_idx +: REG_AW];
  assign sel_data = wb_data[XLEN*gnt_idx +: XLEN];
  // Writes to x0 complete the handshake but never reach the register file.
  assign wr_vld   = gnt_vld && (sel_rd != '0);

  assign iss_ready = !(iss_use_rs1 && busy_q[iss_rs1]) &&
                     !(iss_use_rs2 && busy_q[iss_rs2]) &&
                     !(iss_rd_wen  && busy_q[iss_rd]);
  assign iss_fire  = iss_valid && iss_ready;

  always_comb begin
    busy_d   = busy_q;
    rr_ptr_d = rr_ptr_q;
    wen_d    = wr_vld;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    stall_d  = stall_q;

    // Clear first so a same-edge issue to the same register keeps it busy.
    if (wen_q) busy_d[waddr_q] = 1'b0;
    if (iss_fire && iss_rd_wen && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;

    if (gnt_vld) begin
      rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end

    if (wr_vld) begin
      waddr_d = sel_rd;
      wdata_d = sel_data;
      if (!busy_q[sel_rd]) err_d = 1'b1;
    end

    if (iss_valid && !iss_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q   <= '0;
      rr_ptr_q <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      stall_q  <= '0;
    end else begin
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      stall_q  <= stall_d;
    end
  end

  assign gpr_wen      = wen_q;
  assign gpr_waddr    = waddr_q;
  assign gpr_wdata    = wdata_q;
  assign busy_vec     = busy_q;
  assign err_unexp_wb = err_q;
  assign stall_cnt    = stall_q;

endmodule
